// File: rtl/morse_tx_if.sv
// rtl/morse_tx_if.sv - letter request handshake between a letter source and morse_tx
interface morse_tx_if;
    logic [4:0] letter;
    logic       letter_valid;
    logic       letter_ready;

    modport master (output letter, output letter_valid, input letter_ready);
    modport slave  (input letter, input letter_valid, output letter_ready);
endinterface

// File: rtl/morse_tx.sv
// rtl/morse_tx.sv - keys one letter A..Z as International Morse on an active-low line
// Optional MORSE_TX_WORD_GAP_EN: code 0 sends a 7-unit word gap instead of flagging an error.
module morse_tx #(
    parameter int UNIT_CYCLES = 4194304,
    parameter int DASH_UNITS  = 3,
    parameter int LGAP_UNITS  = 3
) (
    input  logic       CLK,
    input  logic       RST_N,
    morse_tx_if.slave  lt,
    output logic       key_n,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int MAXU = (DASH_UNITS > LGAP_UNITS) ? ((DASH_UNITS > 7) ? DASH_UNITS : 7)
                                                    : ((LGAP_UNITS > 7) ? LGAP_UNITS : 7);
    localparam int CW = $clog2(MAXU * UNIT_CYCLES + 1);
    localparam logic [CW-1:0] DOT_LD  = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] DASH_LD = CW'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] LGAP_LD = CW'(LGAP_UNITS * UNIT_CYCLES - 1);
`ifdef MORSE_TX_WORD_GAP_EN
    localparam logic [CW-1:0] WGAP_LD = CW'(7 * UNIT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {IDLE, MARK, SPACE, LGAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    pat_q, pat_d;
    logic [2:0]    left_q, left_d;
    logic          key_n_q, key_n_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          ready_q, ready_d;
    logic [6:0]    lut;

    // {element count, pattern}; bit 0 of the pattern is sent first, 1 = dash
    function automatic logic [6:0] morse_lut(input logic [4:0] code);
        case (code)
            5'd1:    morse_lut = {3'd2, 4'b0010};
            5'd2:    morse_lut = {3'd4, 4'b0001};
            5'd3:    morse_lut = {3'd4, 4'b0101};
            5'd4:    morse_lut = {3'd3, 4'b0001};
            5'd5:    morse_lut = {3'd1, 4'b0000};
            5'd6:    morse_lut = {3'd4, 4'b0100};
            5'd7:    morse_lut = {3'd3, 4'b0011};
            5'd8:    morse_lut = {3'd4, 4'b0000};
            5'd9:    morse_lut = {3'd2, 4'b0000};
            5'd10:   morse_lut = {3'd4, 4'b1110};
            5'd11:   morse_lut = {3'd3, 4'b0101};
            5'd12:   morse_lut = {3'd4, 4'b0010};
            5'd13:   morse_lut = {3'd2, 4'b0011};
            5'd14:   morse_lut = {3'd2, 4'b0001};
            5'd15:   morse_lut = {3'd3, 4'b0111};
            5'd16:   morse_lut = {3'd4, 4'b0110};
            5'd17:   morse_lut = {3'd4, 4'b1011};
            5'd18:   morse_lut = {3'd3, 4'b0010};
            5'd19:   morse_lut = {3'd3, 4'b0000};
            5'd20:   morse_lut = {3'd1, 4'b0001};
            5'd21:   morse_lut = {3'd3, 4'b0100};
            5'd22:   morse_lut = {3'd4, 4'b1000};
            5'd23:   morse_lut = {3'd3, 4'b0110};
            5'd24:   morse_lut = {3'd4, 4'b1001};
            5'd25:   morse_lut = {3'd4, 4'b1101};
            5'd26:   morse_lut = {3'd4, 4'b0011};
            default: morse_lut = 7'd0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        left_d  = left_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        lut     = morse_lut(lt.letter);
        case (state_q)
            IDLE: begin
                if (lt.letter_valid && ready_q) begin
                    if (lt.letter >= 5'd1 && lt.letter <= 5'd26) begin
                        state_d = MARK;
                        pat_d   = lut[3:0];
                        left_d  = lut[6:4];
                        cnt_d   = lut[0] ? DASH_LD : DOT_LD;
`ifdef MORSE_TX_WORD_GAP_EN
                    end else if (lt.letter == 5'd0) begin
                        state_d = LGAP;
                        cnt_d   = WGAP_LD;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            MARK: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (left_q > 3'd1) begin
                    state_d = SPACE;
                    cnt_d   = DOT_LD;
                    pat_d   = pat_q >> 1;
                    left_d  = left_q - 3'd1;
                end else begin
                    state_d = LGAP;
                    cnt_d   = LGAP_LD;
                end
            end
            SPACE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = MARK;
                    cnt_d   = pat_q[0] ? DASH_LD : DOT_LD;
                end
            end
            default: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
        // outputs follow the next state so they line up with it one cycle later
        key_n_d = (state_d != MARK);
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            left_q  <= '0;
            key_n_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            left_q  <= left_d;
            key_n_q <= key_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign key_n           = key_n_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign lt.letter_ready = ready_q;

endmodule

// File: doc/morse_tx.md
MORSE_TX -- requirements
Module: morse_tx

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 4194304: CLK cycles per Morse time unit, legal range ≥1.
REQ-002 SHALL have parameter DASH_UNITS, default 3: dash mark length in units, legal range ≥2.
REQ-003 SHALL have parameter LGAP_UNITS, default 3: inter-letter space length in units, legal range ≥1.
REQ-004 SHALL have port CLK, input, 1 bit: single clock; all state is clocked on its rising edge.
REQ-005 SHALL have port RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port letter, input, 5 bits: letter code, 1=A through 26=Z.
REQ-007 SHALL have port letter_valid, input, 1 bit: letter holds a request.
REQ-008 SHALL have port letter_ready, output, 1 bit: block can accept a letter.
REQ-009 SHALL have port key_n, output, 1 bit: keyed line, active-low (0 = mark), directly drives a decoder button input.
REQ-010 SHALL have port busy, output, 1 bit: a letter is being sent.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a letter finishes.
REQ-012 SHALL have port err, output, 1 bit: one-cycle pulse when an invalid code is accepted.

Function
REQ-013 SHALL accept a letter on a cycle with letter_valid=1 and letter_ready=1, and latch letter on that cycle; letter need not stay stable afterwards.
REQ-014 SHALL drive letter_ready=1 only in state IDLE; requests presented while letter_ready=0 SHALL be ignored.
REQ-015 SHALL encode codes 1..26 as International Morse A..Z (1 to 4 elements).
REQ-016 SHALL store the element pattern with element i (i=0 is sent first) in bit i, 1=dash, 0=dot, plus an element count 1..4.
REQ-017 SHALL implement states IDLE, MARK, SPACE and LGAP.
REQ-018 SHALL transition IDLE→MARK on acceptance of a valid code, with key_n=0 from the next cycle (latency 1).
REQ-019 SHALL hold key_n=0 in MARK for exactly UNIT_CYCLES cycles for a dot and DASH_UNITS*UNIT_CYCLES cycles for a dash.
REQ-020 SHALL leave MARK for SPACE when elements remain, or for LGAP after the last element.
REQ-021 SHALL hold key_n=1 in SPACE for exactly UNIT_CYCLES cycles, then return to MARK for the next element.
REQ-022 SHALL hold key_n=1 in LGAP for exactly LGAP_UNITS*UNIT_CYCLES cycles, then enter IDLE.
REQ-023 SHALL pulse done=1 for the first IDLE cycle after LGAP, with letter_ready=1 in that same cycle, so back-to-back letters are gap-exact.
REQ-024 SHALL drive busy=1 in MARK, SPACE and LGAP, and busy=0 in IDLE.
REQ-025 SHALL treat code 0 or 27..31 as invalid (except per REQ-031): accepted, err=1 on the next cycle, no keying, remain in IDLE with letter_ready=1.
REQ-026 SHALL size the unit/element down-counter to hold max(DASH_UNITS,LGAP_UNITS,7)*UNIT_CYCLES without wrap.
REQ-027 SHALL hold key_n=1 whenever the state is not MARK.

Reset
REQ-028 SHALL force, while RST_N=0 and asynchronously: state IDLE, key_n=1, letter_ready=0, busy=0, done=0, err=0, counters 0.
REQ-029 SHALL raise letter_ready=1 on the first clock edge after RST_N deasserts.
REQ-030 SHALL, on reset mid-letter, release key_n to 1 immediately and discard the letter without a done pulse.

Configuration
REQ-031 With MORSE_TX_WORD_GAP_EN defined, code 0 SHALL be valid: it enters LGAP directly, holds key_n=1 for 7*UNIT_CYCLES cycles, then pulses done, with no err. Without the macro, code 0 SHALL be invalid per REQ-025 and no word-gap logic SHALL be present.

Verification
(Bench parameters: UNIT_CYCLES=2, DASH_UNITS=3, LGAP_UNITS=3; accept cycle = cycle 0.)
REQ-032 SHALL cover: E (5) → key_n=0 on cycles 1-2, key_n=1 on cycles 3-8, done=1 and letter_ready=1 on cycle 9.
REQ-033 SHALL cover: A (1) → key_n=0 on cycles 1-2, 1 on 3-4, 0 on 5-10, 1 on 11-16, done on cycle 17.
REQ-034 SHALL cover: H (8) then T (20), with letter_valid held high → T's mark starts exactly 1 cycle after H's done cycle; H mark/space pattern is 2/2/2/2/2/2/2 then 6 gap cycles.
REQ-035 SHALL cover: code 27 → err=1 on cycle 1, key_n=1 throughout, letter_ready stays 1; with MORSE_TX_WORD_GAP_EN undefined, code 0 gives the same response.
REQ-036 SHALL cover: RST_N=0 during Q's (17) first dash → key_n=1 in the same cycle, no done; after release, accepting E matches REQ-032.
REQ-037 SHALL cover: with MORSE_TX_WORD_GAP_EN defined, code 0 → key_n=1 and busy=1 on cycles 1-14, done on cycle 15, err=0.
